// File: rtl/fan_cmd_pkg.sv
// Shared constants for the fan-controller command receiver: ASCII codes,
// receiver state encoding and command pulse bit positions.
package fan_cmd_pkg;

    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_F     = 8'h46;
    localparam logic [7:0] CHR_PLUS  = 8'h2B;
    localparam logic [7:0] CHR_MINUS = 8'h2D;
    localparam logic [7:0] CHR_0     = 8'h30;
    localparam logic [7:0] CHR_S     = 8'h53;
    localparam logic [7:0] CHR_R     = 8'h52;
    localparam logic [7:0] CHR_L     = 8'h4C;
    localparam logic [7:0] CHR_T     = 8'h54;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } rx_state_e;

    localparam int NUM_CMD   = 8;
    localparam int CMD_INC   = 0;
    localparam int CMD_BACK  = 1;
    localparam int CMD_IDLE  = 2;
    localparam int CMD_SS    = 3;
    localparam int CMD_ROT   = 4;
    localparam int CMD_LED   = 5;
    localparam int CMD_TIMER = 6;
    localparam int CMD_ERR   = 7;

    function automatic logic is_term(input logic [7:0] b);
        return (b == CHR_CR) || (b == CHR_LF);
    endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Serial input and decoded command outputs of the command receiver.
interface uart_cmd_rx_if;
    logic       uart_rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       wind_inc;
    logic       wind_back;
    logic       fan_idle;
    logic       servo_ss;
    logic       servo_rot;
    logic       led_tog;
    logic       timer_step;
    logic       cmd_err;

    modport master (
        output uart_rx,
        input  rx_byte, rx_valid, wind_inc, wind_back, fan_idle,
               servo_ss, servo_rot, led_tog, timer_step, cmd_err
    );

    modport slave (
        input  uart_rx,
        output rx_byte, rx_valid, wind_inc, wind_back, fan_idle,
               servo_ss, servo_rot, led_tog, timer_step, cmd_err
    );
endinterface

// File: rtl/uart_cmd_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, framing
// error detection with a wait-for-idle-high recovery.
module uart_byte_rx
    import fan_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 13020
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       uart_rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       frame_err_o
);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    rx_state_e        state_q;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q, byte_q;
    logic             vld_q, ferr_q, wait_hi_q;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            vld_q     <= 1'b0;
            ferr_q    <= 1'b0;
            wait_hi_q <= 1'b0;
        end else begin
            sync1_q <= uart_rx_i;
            sync2_q <= sync1_q;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // After a framing error the line must go idle-high before a new start bit counts
                    if (wait_hi_q) begin
                        if (sync2_q) wait_hi_q <= 1'b0;
                    end else if (!sync2_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync2_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (sync2_q) begin
                            byte_q <= shift_q;
                            vld_q  <= 1'b1;
                        end else begin
                            ferr_q    <= 1'b1;
                            wait_hi_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_byte_o   = byte_q;
    assign rx_valid_o  = vld_q;
    assign frame_err_o = ferr_q;
endmodule

// File: rtl/uart_cmd_rx.sv
// Line buffer and exact-match decoder turning received text lines into
// one-cycle, one-hot command pulses.
module uart_cmd_rx
    import fan_cmd_pkg::*;
#(
    parameter int SYS_FREQ = 125,
    parameter int BAUD     = 9600,
    parameter int MAX_LEN  = 8
) (
    input  logic          clk,
    input  logic          reset_p,
    uart_cmd_rx_if.slave  bus
);
    localparam int CLKS_PER_BIT = SYS_FREQ * 1_000_000 / BAUD;
    localparam int LEN_W        = $clog2(MAX_LEN + 1);
    localparam int IDX_W        = $clog2(MAX_LEN);

    typedef logic [MAX_LEN-1:0][7:0] line_t;

    logic [7:0]         byte_w;
    logic               vld_w, ferr_w;
    line_t              buf_q;
    logic [LEN_W-1:0]   len_q;
    logic               bad_q, ovf_q;
    logic [NUM_CMD-1:0] cmd_q, dec, cmd_d;
    logic               term, fire;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
        .clk         (clk),
        .reset_p     (reset_p),
        .uart_rx_i   (bus.uart_rx),
        .rx_byte_o   (byte_w),
        .rx_valid_o  (vld_w),
        .frame_err_o (ferr_w)
    );

    // Unused buffer slots are always zero, so a whole-buffer compare is an exact match
    function automatic line_t pat(input logic [7:0] c0, input logic [7:0] c1);
        line_t p;
        p    = '0;
        p[0] = c0;
        p[1] = c1;
        return p;
    endfunction

    always_comb begin
        dec = '0;
        if (bad_q || ovf_q)                                        dec[CMD_ERR]   = 1'b1;
        else if (len_q == LEN_W'(2) && buf_q == pat(CHR_F, CHR_PLUS))  dec[CMD_INC]   = 1'b1;
        else if (len_q == LEN_W'(2) && buf_q == pat(CHR_F, CHR_MINUS)) dec[CMD_BACK]  = 1'b1;
        else if (len_q == LEN_W'(2) && buf_q == pat(CHR_F, CHR_0))     dec[CMD_IDLE]  = 1'b1;
        else if (len_q == LEN_W'(1) && buf_q == pat(CHR_S, 8'h00))     dec[CMD_SS]    = 1'b1;
        else if (len_q == LEN_W'(1) && buf_q == pat(CHR_R, 8'h00))     dec[CMD_ROT]   = 1'b1;
        else if (len_q == LEN_W'(1) && buf_q == pat(CHR_L, 8'h00))     dec[CMD_LED]   = 1'b1;
        else if (len_q == LEN_W'(1) && buf_q == pat(CHR_T, 8'h00))     dec[CMD_TIMER] = 1'b1;
        else                                                       dec[CMD_ERR]   = 1'b1;
        term  = vld_w && is_term(byte_w);
        fire  = term && (len_q != '0 || bad_q);
        cmd_d = fire ? dec : '0;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            buf_q <= '0;
            len_q <= '0;
            bad_q <= 1'b0;
            ovf_q <= 1'b0;
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
            if (ferr_w) bad_q <= 1'b1;
            if (fire) begin
                buf_q <= '0;
                len_q <= '0;
                bad_q <= 1'b0;
                ovf_q <= 1'b0;
            end else if (vld_w && !term) begin
                if (len_q < LEN_W'(MAX_LEN)) begin
                    buf_q[len_q[IDX_W-1:0]] <= byte_w;
                    len_q <= len_q + LEN_W'(1);
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rx_byte    = byte_w;
    assign bus.rx_valid   = vld_w;
    assign bus.wind_inc   = cmd_q[CMD_INC];
    assign bus.wind_back  = cmd_q[CMD_BACK];
    assign bus.fan_idle   = cmd_q[CMD_IDLE];
    assign bus.servo_ss   = cmd_q[CMD_SS];
    assign bus.servo_rot  = cmd_q[CMD_ROT];
    assign bus.led_tog    = cmd_q[CMD_LED];
    assign bus.timer_step = cmd_q[CMD_TIMER];
    assign bus.cmd_err    = cmd_q[CMD_ERR];
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: a string-level line model predicts the
// received bytes and command pulses; a negedge monitor pops and compares.
module tb_uart_cmd_rx;
    localparam int CPB     = 10;
    localparam int MAX_LEN = 8;
    // command codes: bit index in {err,timer,led,rot,ss,idle,back,inc}
    localparam int C_INC = 0, C_BACK = 1, C_IDLE = 2, C_SS = 3, C_ROT = 4;
    localparam int C_LED = 5, C_TIMER = 6, C_ERR = 7;

    logic clk = 1'b0;
    logic reset_p = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_rx_if bus();

    uart_cmd_rx #(.SYS_FREQ(1), .BAUD(100_000), .MAX_LEN(MAX_LEN)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus)
    );

    logic [7:0] exp_bytes[$];
    int         exp_cmd[$];
    logic [7:0] line[$];
    logic       m_bad = 1'b0;
    logic       done = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // ---------------- reference model ----------------
    function automatic int decode_line(input string s, input logic bad, input int n);
        if (bad || n > MAX_LEN) return C_ERR;
        case (s)
            "F+":    return C_INC;
            "F-":    return C_BACK;
            "F0":    return C_IDLE;
            "S":     return C_SS;
            "R":     return C_ROT;
            "L":     return C_LED;
            "T":     return C_TIMER;
            default: return C_ERR;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        string s, t;
        exp_bytes.push_back(b);
        if (b == 8'h0D || b == 8'h0A) begin
            if (line.size() == 0 && !m_bad) return;
            s = "";
            t = " ";
            foreach (line[i]) begin
                t[0] = line[i];
                s = {s, t};
            end
            exp_cmd.push_back(decode_line(s, m_bad, line.size()));
            line.delete();
            m_bad = 1'b0;
        end else begin
            line.push_back(b);
        end
    endtask

    // ---------------- line driver (all edges at negedge) ----------------
    task automatic drive(input logic v, input int n);
        bus.uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop, CPB);
        if (!stop) drive(1'b1, 2 * CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        model_byte(b);
        send_frame(b, 1'b1);
        if (gap > 0) drive(1'b1, gap);
    endtask

    task automatic send_str(input string s, input logic back2back);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], back2back ? 0 : $urandom_range(0, 15));
    endtask

    task automatic send_bad(input logic [7:0] b);
        m_bad = 1'b1;
        send_frame(b, 1'b0);
    endtask

    task automatic glitch();
        drive(1'b0, 4);
        drive(1'b1, 3 * CPB);
    endtask

    task automatic reset_mid_frame(input logic [7:0] b);
        drive(1'b0, CPB);
        for (int i = 0; i < 3; i++) drive(b[i], CPB);
        reset_p = 1'b1;
        bus.uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        line.delete();
        m_bad = 1'b0;
        reset_p = 1'b0;
        drive(1'b1, 2 * CPB);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] outs;
    logic       prev_term = 1'b0;
    logic       rst_d = 1'b0;
    assign outs = {bus.cmd_err, bus.timer_step, bus.led_tog, bus.servo_rot,
                   bus.servo_ss, bus.fan_idle, bus.wind_back, bus.wind_inc};

    always @(negedge clk) begin
        if (reset_p) begin
            if (rst_d) begin
                checks++;
                if (outs != 8'h00 || bus.rx_valid || bus.rx_byte != 8'h00) begin
                    errors++;
                    $display("FAIL reset_state outs=%b vld=%b byte=%h want all 0",
                             outs, bus.rx_valid, bus.rx_byte);
                end
            end
        end else begin
            if (bus.rx_valid) begin
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL rx_byte unexpected strobe got %h want none", bus.rx_byte);
                end else begin
                    logic [7:0] eb;
                    eb = exp_bytes.pop_front();
                    if (bus.rx_byte != eb) begin
                        errors++;
                        $display("FAIL rx_byte got %h want %h", bus.rx_byte, eb);
                    end
                end
            end
            if (outs != 8'h00) begin
                checks++;
                if (exp_cmd.size() == 0) begin
                    errors++;
                    $display("FAIL cmd unexpected pulse got %b want none", outs);
                end else begin
                    int ec;
                    logic [7:0] ev;
                    ec = exp_cmd.pop_front();
                    ev = 8'h01 << ec;
                    if (outs != ev || !prev_term) begin
                        errors++;
                        $display("FAIL cmd got %b (after_term=%b) want %b one cycle after terminator",
                                 outs, prev_term, ev);
                    end
                end
            end
        end
        if (done) begin
            checks++;
            if (exp_bytes.size() != 0 || exp_cmd.size() != 0) begin
                errors++;
                $display("FAIL drain pending bytes=%0d cmds=%0d want 0 0",
                         exp_bytes.size(), exp_cmd.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        rst_d     <= reset_p;
        prev_term <= bus.rx_valid && (bus.rx_byte == 8'h0D || bus.rx_byte == 8'h0A);
    end

    // ---------------- stimulus ----------------
    string pool[14];
    initial begin
        pool = '{"F+", "F-", "F0", "S", "R", "L", "T", "X", "f+", "F", "SS", "F+A", "", "TTTTTTTTT"};
        bus.uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_p = 1'b0;
        drive(1'b1, 2 * CPB);

        send_str("F+\r", 1'b0);
        send_str("T\r\nL\n", 1'b1);
        send_str("X\rF+A\r", 1'b0);
        send_str("SSSSSSSSS\r", 1'b0);
        send_str("S\r", 1'b0);
        send_bad(8'h46);
        send_str("+\r", 1'b0);
        glitch();
        reset_mid_frame(8'h52);
        send_str("R\r", 1'b0);
        send_str("F-\rF0\r\r\n", 1'b1);

        for (int n = 0; n < 30; n++) begin
            int k;
            k = $urandom_range(0, 13);
            if ($urandom_range(0, 9) == 0) send_bad(8'($urandom_range(32, 126)));
            if ($urandom_range(0, 9) == 0) glitch();
            send_str(pool[k], 1'b0);
            case ($urandom_range(0, 2))
                0:       send_str("\r", 1'b0);
                1:       send_str("\n", 1'b0);
                default: send_str("\r\n", 1'b1);
            endcase
        end

        drive(1'b1, 5 * CPB);
        done = 1'b1;
    end
endmodule
